// File: rtl/vram_port_arbiter_if.sv
// Signal bundle between a VRAM instance, the pixel generator and the CPU access port.
// slave is the arbiter's view; master is the surrounding system's view.
interface vram_port_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 11
);
   logic                     cpu_req;
   logic                     cpu_we;
   logic [ADDRESS_WIDTH-1:0] cpu_addr;
   logic [7:0]               cpu_wdata;
   logic                     cpu_ready;
   logic [7:0]               cpu_rdata;
   logic                     cpu_rdata_valid;
   logic                     pg_read_enable;
   logic [ADDRESS_WIDTH-1:0] pg_read_addr;
   logic [7:0]               pg_read_data;
   logic                     mem_read_enable;
   logic [ADDRESS_WIDTH-1:0] mem_read_addr;
   logic [7:0]               mem_read_data;
   logic                     mem_write_enable;
   logic [ADDRESS_WIDTH-1:0] mem_write_addr;
   logic [7:0]               mem_write_data;
   logic [15:0]              cpu_stall_count;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  pg_read_enable, pg_read_addr, mem_read_data,
      output cpu_ready, cpu_rdata, cpu_rdata_valid, pg_read_data,
      output mem_read_enable, mem_read_addr,
      output mem_write_enable, mem_write_addr, mem_write_data,
      output cpu_stall_count
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output pg_read_enable, pg_read_addr, mem_read_data,
      input  cpu_ready, cpu_rdata, cpu_rdata_valid, pg_read_data,
      input  mem_read_enable, mem_read_addr,
      input  mem_write_enable, mem_write_addr, mem_write_data,
      input  cpu_stall_count
   );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one VRAM between pixel-generator reads (always win) and an in-order queue of
// CPU reads/writes. CPU read data returns two clocks after the read issues.
module vram_port_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 11,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input logic                clk,
   input logic                rst,
   vram_port_arbiter_if.slave bus
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

   logic                     fifo_we_q    [FIFO_DEPTH];
   logic [ADDRESS_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
   logic [7:0]               fifo_wdata_q [FIFO_DEPTH];

   logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
   logic [PtrW-1:0] wr_idx, rd_idx;
   logic            full, empty;
   logic            push, pop, write_issue, cpu_issue, stall;

   logic                     head_we;
   logic [ADDRESS_WIDTH-1:0] head_addr;
   logic [7:0]               head_wdata;

   logic        owner_q;
   logic [7:0]  cpu_rdata_q;
   logic        cpu_rdata_valid_q;
   logic [15:0] stall_count_q;

   assign wr_idx = wr_ptr_q[PtrW-1:0];
   assign rd_idx = rd_ptr_q[PtrW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);

   always_comb begin
      head_we     = fifo_we_q[rd_idx];
      head_addr   = fifo_addr_q[rd_idx];
      head_wdata  = fifo_wdata_q[rd_idx];
      push        = bus.cpu_req && !full;
      // A blocked read at the head also holds back any writes queued behind it.
      write_issue = !empty && head_we;
      cpu_issue   = !empty && !head_we && !bus.pg_read_enable;
      stall       = !empty && !head_we && bus.pg_read_enable;
      pop         = write_issue || cpu_issue;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we_q[wr_idx]    <= bus.cpu_we;
         fifo_addr_q[wr_idx]  <= bus.cpu_addr;
         fifo_wdata_q[wr_idx] <= bus.cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         owner_q           <= 1'b0;
         cpu_rdata_q       <= 8'h00;
         cpu_rdata_valid_q <= 1'b0;
         stall_count_q     <= 16'h0000;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
         // owner_q marks the cycle in which memory data belongs to the CPU.
         owner_q           <= cpu_issue;
         cpu_rdata_valid_q <= owner_q;
         if (owner_q) cpu_rdata_q <= bus.mem_read_data;
         if (stall && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign bus.cpu_ready        = !full;
   assign bus.cpu_rdata        = cpu_rdata_q;
   assign bus.cpu_rdata_valid  = cpu_rdata_valid_q;
   assign bus.cpu_stall_count  = stall_count_q;
   assign bus.pg_read_data     = bus.mem_read_data;
   assign bus.mem_read_enable  = bus.pg_read_enable || cpu_issue;
   assign bus.mem_read_addr    = bus.pg_read_enable ? bus.pg_read_addr : head_addr;
   assign bus.mem_write_enable = write_issue;
   assign bus.mem_write_addr   = head_addr;
   assign bus.mem_write_data   = head_wdata;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 1-clk-latency VRAM model.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_vram_port_arbiter;
   localparam int unsigned AW = 11;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   vram_port_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

   vram_port_arbiter #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // VRAM model: contents reload to addr[7:0]^8'hC3 while rst is high.
   logic [7:0] vram [2048];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2048; i++) vram[i] <= 8'(i) ^ 8'hC3;
      end else begin
         if (bus.mem_write_enable) vram[bus.mem_write_addr] <= bus.mem_write_data;
         if (bus.mem_read_enable) bus.mem_read_data <= vram[bus.mem_read_addr];
      end
   end

   task automatic idle_inputs();
      bus.cpu_req        = 1'b0;
      bus.cpu_we         = 1'b0;
      bus.cpu_addr       = '0;
      bus.cpu_wdata      = 8'h00;
      bus.pg_read_enable = 1'b0;
      bus.pg_read_addr   = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cpu_push(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cpu_ready); end
      checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.cpu_rdata); end
      checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.cpu_rdata_valid); end
      checks++; if (bus.cpu_stall_count !== 16'h0000) begin errors++; $display("FAIL reset_stall: got %h expected 0000", bus.cpu_stall_count); end
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_write_enable); end
      checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b expected 0", bus.mem_read_enable); end
      @(negedge clk);
   endtask

   task automatic test_single_write();
      apply_reset();
      cpu_push(1'b1, 11'h010, 8'hA5);
      #1;
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL sw_push_cycle_we: got %b expected 0", bus.mem_write_enable); end
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1;
      checks++; if (bus.mem_write_enable !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", bus.mem_write_enable); end
      checks++; if (bus.mem_write_addr !== 11'h010) begin errors++; $display("FAIL sw_addr: got %h expected 010", bus.mem_write_addr); end
      checks++; if (bus.mem_write_data !== 8'hA5) begin errors++; $display("FAIL sw_data: got %h expected a5", bus.mem_write_data); end
      checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b expected 1", bus.cpu_ready); end
      @(negedge clk);
      #1;
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL sw_we_after: got %b expected 0", bus.mem_write_enable); end
      @(negedge clk);
   endtask

   task automatic test_read_after_write();
      apply_reset();
      cpu_push(1'b1, 11'h020, 8'h3C);
      @(negedge clk);
      cpu_push(1'b0, 11'h020, 8'h00);
      #1;
      checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_addr !== 11'h020) begin errors++; $display("FAIL raw_write: got we=%b addr=%h expected we=1 addr=020", bus.mem_write_enable, bus.mem_write_addr); end
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1;
      checks++; if (bus.mem_read_enable !== 1'b1 || bus.mem_read_addr !== 11'h020) begin errors++; $display("FAIL raw_issue: got re=%b addr=%h expected re=1 addr=020", bus.mem_read_enable, bus.mem_read_addr); end
      @(negedge clk);
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL raw_valid_early: got %b expected 0", bus.cpu_rdata_valid); end
      @(negedge clk);
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b1) begin errors++; $display("FAIL raw_valid: got %b expected 1", bus.cpu_rdata_valid); end
      checks++; if (bus.cpu_rdata !== 8'h3C) begin errors++; $display("FAIL raw_rdata: got %h expected 3c", bus.cpu_rdata); end
      @(negedge clk);
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL raw_valid_late: got %b expected 0", bus.cpu_rdata_valid); end
      checks++; if (bus.cpu_rdata !== 8'h3C) begin errors++; $display("FAIL raw_rdata_hold: got %h expected 3c", bus.cpu_rdata); end
      @(negedge clk);
   endtask

   task automatic test_pg_priority();
      apply_reset();
      cpu_push(1'b0, 11'h007, 8'h00);
      #1;
      checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL pg_push_cycle_re: got %b expected 0", bus.mem_read_enable); end
      @(negedge clk);
      bus.cpu_req        = 1'b0;
      bus.pg_read_enable = 1'b1;
      bus.pg_read_addr   = 11'h005;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (bus.mem_read_addr !== 11'h005) begin errors++; $display("FAIL pg_addr[%0d]: got %h expected 005", i, bus.mem_read_addr); end
         checks++; if (bus.cpu_stall_count !== 16'(i)) begin errors++; $display("FAIL pg_stall[%0d]: got %0d expected %0d", i, bus.cpu_stall_count, i); end
         if (i == 1) begin
            checks++; if (bus.pg_read_data !== 8'hC6) begin errors++; $display("FAIL pg_data: got %h expected c6", bus.pg_read_data); end
         end
         @(negedge clk);
      end
      bus.pg_read_enable = 1'b0;
      #1;
      checks++; if (bus.mem_read_enable !== 1'b1 || bus.mem_read_addr !== 11'h007) begin errors++; $display("FAIL pg_cpu_issue: got re=%b addr=%h expected re=1 addr=007", bus.mem_read_enable, bus.mem_read_addr); end
      checks++; if (bus.cpu_stall_count !== 16'd6) begin errors++; $display("FAIL pg_stall_total: got %0d expected 6", bus.cpu_stall_count); end
      @(negedge clk);
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL pg_valid_early: got %b expected 0", bus.cpu_rdata_valid); end
      @(negedge clk);
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b1 || bus.cpu_rdata !== 8'hC4) begin errors++; $display("FAIL pg_cpu_rdata: got valid=%b data=%h expected valid=1 data=c4", bus.cpu_rdata_valid, bus.cpu_rdata); end
      @(negedge clk);
   endtask

   task automatic test_full_fifo();
      logic [7:0] exp_data [4];
      logic [7:0] got_data [8];
      int         got_cyc  [8];
      int         n;
      exp_data = '{8'hF3, 8'hF2, 8'hF1, 8'hF0};
      n = 0;
      apply_reset();
      bus.pg_read_enable = 1'b1;
      bus.pg_read_addr   = 11'h100;
      for (int i = 0; i < 4; i++) begin
         cpu_push(1'b0, 11'(11'h030 + i), 8'h00);
         #1;
         checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b expected 1", i, bus.cpu_ready); end
         @(negedge clk);
      end
      cpu_push(1'b0, 11'h034, 8'h00);
      #1;
      checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_full: got %b expected 0", bus.cpu_ready); end
      @(negedge clk);
      bus.cpu_req        = 1'b0;
      bus.pg_read_enable = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (k == 0) begin
            checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL full_no_pushthrough: got %b expected 0", bus.cpu_ready); end
         end
         if (k == 1) begin
            checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b expected 1", bus.cpu_ready); end
         end
         if (bus.cpu_rdata_valid === 1'b1 && n < 8) begin
            got_data[n] = bus.cpu_rdata;
            got_cyc[n]  = k;
            n++;
         end
         @(negedge clk);
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL full_pulse_count: got %0d expected 4", n); end
      for (int j = 0; j < 4; j++) begin
         if (j < n) begin
            checks++; if (got_data[j] !== exp_data[j] || got_cyc[j] !== 2 + j) begin errors++; $display("FAIL full_pulse[%0d]: got data=%h cyc=%0d expected data=%h cyc=%0d", j, got_data[j], got_cyc[j], exp_data[j], 2 + j); end
         end
      end
   endtask

   task automatic test_write_behind_read();
      apply_reset();
      bus.pg_read_enable = 1'b1;
      bus.pg_read_addr   = 11'h050;
      cpu_push(1'b0, 11'h001, 8'h00);
      @(negedge clk);
      cpu_push(1'b1, 11'h002, 8'h77);
      #1;
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL wbr_we_push: got %b expected 0", bus.mem_write_enable); end
      @(negedge clk);
      bus.cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL wbr_we_blocked[%0d]: got %b expected 0", i, bus.mem_write_enable); end
         @(negedge clk);
      end
      bus.pg_read_enable = 1'b0;
      #1;
      checks++; if (bus.mem_read_enable !== 1'b1 || bus.mem_read_addr !== 11'h001 || bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL wbr_read_issue: got re=%b addr=%h we=%b expected re=1 addr=001 we=0", bus.mem_read_enable, bus.mem_read_addr, bus.mem_write_enable); end
      checks++; if (bus.cpu_stall_count !== 16'd4) begin errors++; $display("FAIL wbr_stall: got %0d expected 4", bus.cpu_stall_count); end
      @(negedge clk);
      #1;
      checks++; if (bus.mem_write_enable !== 1'b1 || bus.mem_write_addr !== 11'h002 || bus.mem_write_data !== 8'h77) begin errors++; $display("FAIL wbr_write: got we=%b addr=%h data=%h expected we=1 addr=002 data=77", bus.mem_write_enable, bus.mem_write_addr, bus.mem_write_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      cpu_push(1'b0, 11'h009, 8'h00);
      @(negedge clk);
      cpu_push(1'b0, 11'h00A, 8'h00);
      bus.pg_read_enable = 1'b1;
      @(negedge clk);
      bus.cpu_req        = 1'b0;
      bus.pg_read_enable = 1'b0;
      #1;
      checks++; if (bus.mem_read_enable !== 1'b1 || bus.mem_read_addr !== 11'h009) begin errors++; $display("FAIL rmr_issue: got re=%b addr=%h expected re=1 addr=009", bus.mem_read_enable, bus.mem_read_addr); end
      checks++; if (bus.cpu_stall_count !== 16'd1) begin errors++; $display("FAIL rmr_stall_pre: got %0d expected 1", bus.cpu_stall_count); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid_rst: got %b expected 0", bus.cpu_rdata_valid); end
      checks++; if (bus.cpu_stall_count !== 16'd0) begin errors++; $display("FAIL rmr_stall_rst: got %0d expected 0", bus.cpu_stall_count); end
      checks++; if (bus.cpu_ready !== 1'b1) begin errors++; $display("FAIL rmr_ready_rst: got %b expected 1", bus.cpu_ready); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.cpu_rdata_valid !== 1'b0) begin errors++; $display("FAIL rmr_valid_after[%0d]: got %b expected 0", i, bus.cpu_rdata_valid); end
         checks++; if (bus.mem_read_enable !== 1'b0) begin errors++; $display("FAIL rmr_fifo_empty[%0d]: got re=%b expected 0", i, bus.mem_read_enable); end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      bus.mem_read_data = 8'h00;
      test_reset();
      test_single_write();
      test_read_after_write();
      test_pg_priority();
      test_full_fifo();
      test_write_behind_read();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one VRAM instance (tile, attribute or color memory) between the pixel_generator read port and a CPU access port.
- pixel_generator reads always win, so display fetches are never delayed.
- CPU reads and writes are queued in a small in-order FIFO.
  - Writes drain onto the memory write port.
  - Reads issue only in clk cycles where the pixel generator is not reading.
- Instantiated once per memory, between the memory and pixel_generator, all on the 100 MHz clk.

Parameters:
ADDRESS_WIDTH, 11, VRAM address width (12 for attribute, 4 for color).
FIFO_DEPTH, 4, CPU request queue entries; power of two, minimum 2.

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  reset, asynchronous, active-high.
cpu_req  in  1  CPU request strobe; accepted when cpu_ready=1.
cpu_we  in  1  1=write, 0=read.
cpu_addr  in  ADDRESS_WIDTH  CPU address.
cpu_wdata  in  8  CPU write data.
cpu_ready  out  1  FIFO not full.
cpu_rdata  out  8  CPU read result.
cpu_rdata_valid  out  1  one-clk pulse, cpu_rdata valid.
pg_read_enable  in  1  pixel_generator read request.
pg_read_addr  in  ADDRESS_WIDTH  pixel_generator read address.
pg_read_data  out  8  pixel_generator read data.
mem_read_enable  out  1  to memory read_enable.
mem_read_addr  out  ADDRESS_WIDTH  to memory read_addr.
mem_read_data  in  8  from memory read_data (1-clk synchronous latency).
mem_write_enable  out  1  to memory write_enable.
mem_write_addr  out  ADDRESS_WIDTH  to memory write_addr.
mem_write_data  out  8  to memory write_data.
cpu_stall_count  out  16  saturating count of clk cycles a CPU read at FIFO head was blocked.

Behaviour:
Reset (async assert, sync release):
- FIFO empty, cpu_ready=1, cpu_rdata=0, cpu_rdata_valid=0, cpu_stall_count=0, internal read-owner pipeline cleared.
- Reset mid-operation discards queued requests and any in-flight CPU read; no valid pulse follows.

FIFO push and pop:
- Push when cpu_req && cpu_ready, capturing {we, addr, wdata}.
- When full, cpu_ready=0 even if a pop happens the same cycle; no push-through.
- Simultaneous push and pop when not full is legal; occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty uses an extra pointer bit.
- An entry pushed into an empty FIFO becomes head the next cycle; it is never serviced in its push cycle.

Head service (combinational from the head, registered FIFO):
- Head is a write: mem_write_enable=1, mem_write_addr/data taken from the head, pop this cycle, independent of pg_read_enable.
- Head is a read and pg_read_enable=0: issue the CPU read, pop this cycle.
- Head is a read and pg_read_enable=1: hold the head, cpu_stall_count += 1 (saturates at 16'hFFFF).
- Strict in-order service: a blocked read also blocks later writes. A read after a write to the same address returns the new data.

Read port mux:
- mem_read_enable = pg_read_enable | cpu_issue.
- mem_read_addr = pg_read_addr when pg_read_enable, otherwise the head address.

Read return:
- A 1-bit owner flag is registered at each issue edge.
- pg_read_data = mem_read_data, passed through combinationally with no added latency.
- CPU read issued in cycle N: memory data is valid in N+1 and registered into cpu_rdata at the end of N+1. cpu_rdata_valid is high for exactly cycle N+2.
- cpu_rdata holds its value until the next CPU read returns.
- CPU read throughput is one per clk when the pixel generator is idle.

Memory write port: when idle, mem_write_enable=0 and mem_write_addr/data are don't-care (drive the head values).

Test Plan:
- Single write: reset, push write addr 0x010 data 0xA5 with pg idle -> mem_write_enable high one clk with addr 0x010/data 0xA5 the cycle after the push; cpu_ready stays 1.
- Read-after-write: push write 0x020=0x3C then read 0x020, pg idle -> cpu_rdata_valid pulses once with cpu_rdata=0x3C.
- PG priority: hold pg_read_enable=1 at addr 0x005 for 6 clks while a CPU read of 0x007 is queued -> mem_read_addr=0x005 throughout, CPU read issues the first clk after pg drops, cpu_stall_count=6, data valid 2 clks after issue.
- Full FIFO: hold pg_read_enable=1, push 5 reads -> first 4 accepted, cpu_ready=0 on the 5th; release pg -> 4 valid pulses on consecutive clks, in order, cpu_ready returns to 1.
- Write behind a blocked read: queue read 0x001 then write 0x002=0x77 with pg busy -> no write occurs until the read issues; the write appears on the next clk.
- Reset mid-read: issue a CPU read, assert rst the next clk -> no cpu_rdata_valid pulse, FIFO empty, cpu_stall_count=0.
